// File: rtl/mant_mul_pkg.sv
// Shared constants and helpers for the mantissa-multiplier scheduler:
// precision codes, partial-product masks and the issue-stage payload.
package mant_mul_pkg;

    localparam logic [1:0] PREC_FULL = 2'd0;
    localparam logic [1:0] PREC_HI   = 2'd1;
    localparam logic [1:0] PREC_MID  = 2'd2;
    localparam logic [1:0] PREC_LOW  = 2'd3;

    localparam logic [10:0] MASK_FULL = 11'h7FF;
    localparam logic [10:0] MASK_HI   = 11'h7F8;
    localparam logic [10:0] MASK_MID  = 11'h7C0;
    localparam logic [10:0] MASK_LOW  = 11'h700;

    typedef struct packed {
        logic [7:0]  manta;
        logic [7:0]  mantb;
        logic [1:0]  prec;
        logic [10:0] mask;
    } issue_t;

    function automatic logic [10:0] prec_to_mask(input logic [1:0] prec);
        logic [10:0] mask;
        case (prec)
            PREC_FULL: mask = MASK_FULL;
            PREC_HI:   mask = MASK_HI;
            PREC_MID:  mask = MASK_MID;
            PREC_LOW:  mask = MASK_LOW;
            default:   mask = MASK_FULL;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/mant_mul.sv
// Radix-4 Booth mantissa multiplier: five masked partial products taken
// from product bits [15:5], reduced by a 3:2 CSA chain to sum/carry.
module mant_mul (
    input  logic [7:0]  manta,
    input  logic [7:0]  mantb,
    input  logic [10:0] mask,
    output logic [10:0] mults,
    output logic [10:0] multc
);

    function automatic logic [15:0] booth_pp(input logic [7:0] a, input logic [2:0] trip);
        logic [15:0] pp;
        case (trip)
            3'b001, 3'b010: pp = {8'd0, a};
            3'b011:         pp = {7'd0, a, 1'b0};
            3'b100:         pp = ~{7'd0, a, 1'b0} + 16'd1;
            3'b101, 3'b110: pp = ~{8'd0, a} + 16'd1;
            default:        pp = 16'd0;
        endcase
        return pp;
    endfunction

    // Returns {carry, sum}; carry has weight 2.
    function automatic logic [21:0] csa(input logic [10:0] x, input logic [10:0] y,
                                        input logic [10:0] z);
        return {(x & y) | (x & z) | (y & z), x ^ y ^ z};
    endfunction

    logic [10:0] bext;
    logic [15:0] pp0, pp1, pp2, pp3, pp4;
    logic [10:0] w0, w1, w2, w3, w4;
    logic [21:0] r1, r2, r3;

    // Booth recoding and masked windowing of each partial product.
    always_comb begin
        bext = {2'b00, mantb, 1'b0};
        pp0  = booth_pp(manta, bext[2:0]);
        pp1  = booth_pp(manta, bext[4:2])  << 2;
        pp2  = booth_pp(manta, bext[6:4])  << 4;
        pp3  = booth_pp(manta, bext[8:6])  << 6;
        pp4  = booth_pp(manta, bext[10:8]) << 8;
        w0   = pp0[15:5] & mask;
        w1   = pp1[15:5] & mask;
        w2   = pp2[15:5] & mask;
        w3   = pp3[15:5] & mask;
        w4   = pp4[15:5] & mask;
    end

    // Carry-save reduction of the five windows down to sum/carry.
    always_comb begin
        r1    = csa(w0, w1, w2);
        r2    = csa(r1[10:0], {r1[20:11], 1'b0}, w3);
        r3    = csa(r2[10:0], {r2[20:11], 1'b0}, w4);
        mults = r3[10:0];
        multc = r3[21:11];
    end

endmodule

// File: rtl/mant_mul_sched_rr_arbiter.sv
// Round-robin arbiter: picks the first asserted request at or above ptr,
// wrapping around; returns a one-hot grant and its index.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  gidx
);

    int idx;

    // Scan from the farthest candidate back to ptr so the nearest one wins.
    always_comb begin
        grant = '0;
        gidx  = '0;
        idx   = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NREQ;
            if (|(req & (NREQ'(1'b1) << idx))) begin
                grant = NREQ'(1'b1) << idx;
                gidx  = IDW'(idx);
            end else begin
                grant = grant;
            end
        end
    end

endmodule

// File: rtl/mant_mul_sched.sv
// Shares one mantissa multiplier between NREQ requesters: round-robin issue
// register feeding the multiplier, then a result register under backpressure.
module mant_mul_sched
    import mant_mul_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*8-1:0] req_manta,
    input  logic [NREQ*8-1:0] req_mantb,
    input  logic [NREQ*2-1:0] req_prec,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [IDW-1:0]    resp_id,
    output logic [1:0]        resp_prec,
    output logic [10:0]       resp_data,
    output logic              busy
);

    logic            v1, v2;
    logic [IDW-1:0]  id1, id2, rr, rr_next, gidx;
    issue_t          op1, op_in;
    logic [1:0]      prec2;
    logic [10:0]     mults, multc, mults2, multc2;
    logic [NREQ-1:0] grant;
    logic            adv1, adv2, accept;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req   (req_valid),
        .ptr   (rr),
        .grant (grant),
        .gidx  (gidx)
    );

    mant_mul u_mul (
        .manta (op1.manta),
        .mantb (op1.mantb),
        .mask  (op1.mask),
        .mults (mults),
        .multc (multc)
    );

    // Handshake, stall chain and operand selection for the granted requester.
    always_comb begin
        adv2            = !v2 || resp_ready;
        adv1            = !v1 || adv2;
        req_ready       = '0;
        if (!rst && adv1) begin
            req_ready = grant & req_valid;
        end else begin
            req_ready = '0;
        end
        accept          = |req_ready;
        op_in.manta     = req_manta[int'(gidx)*8 +: 8];
        op_in.mantb     = req_mantb[int'(gidx)*8 +: 8];
        op_in.prec      = req_prec[int'(gidx)*2 +: 2];
        op_in.mask      = prec_to_mask(op_in.prec);
        if (gidx == IDW'(NREQ - 1)) begin
            rr_next = '0;
        end else begin
            rr_next = gidx + 1'b1;
        end
    end

    // Issue stage and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1  <= 1'b0;
            id1 <= '0;
            op1 <= '0;
            rr  <= '0;
        end else if (accept) begin
            v1  <= 1'b1;
            id1 <= gidx;
            op1 <= op_in;
            rr  <= rr_next;
        end else if (adv1) begin
            v1  <= 1'b0;
        end
    end

    // Result stage: captures the multiplier's sum/carry for the issued entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2     <= 1'b0;
            id2    <= '0;
            prec2  <= 2'd0;
            mults2 <= 11'd0;
            multc2 <= 11'd0;
        end else if (adv2) begin
            v2     <= v1;
            id2    <= id1;
            prec2  <= op1.prec;
            mults2 <= mults;
            multc2 <= multc;
        end
    end

    assign resp_valid = v2;
    assign resp_id    = id2;
    assign resp_prec  = prec2;
    assign resp_data  = mults2 + {multc2[9:0], 1'b0};
    assign busy       = v1 | v2;

endmodule

// File: doc/mant_mul_sched.md
Name: mant_mul_sched

Overview:
- Round-robin scheduler that shares one variable-precision mantissa multiplier (Booth radix-4, CSA-reduced, 11-bit masked sum/carry output) between NREQ independent requesters.
- Arbitrates requests and decodes each request's precision mode into the 11-bit partial-product mask.
- Drives the multiplier from a registered issue stage, then resolves sum/carry in a second registered stage.
- Returns tagged results under valid/ready backpressure. Sits between the BF16 lane front-ends and the exponent/normalise stage.

Parameters:
NREQ, 2, number of requesters (2..4)
IDW, 2, width of resp_id; must satisfy 2**IDW >= NREQ

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester accept; at most one bit high per cycle
req_manta  in  NREQ*8  per-requester mantissa A, requester i at [8i+7:8i]
req_mantb  in  NREQ*8  per-requester mantissa B, same packing
req_prec  in  NREQ*2  per-requester precision mode, same packing (2 bits each)
resp_valid  out  1  result valid
resp_ready  in  1  downstream accept
resp_id  out  IDW  index of the requester that owns the result
resp_prec  out  2  precision mode that produced the result
resp_data  out  11  resolved product: (mults + (multc<<1)) mod 2^11
busy  out  1  high when either pipeline stage holds a valid entry

Behaviour:
- Reset, asynchronous: all stage valids = 0; resp_valid = 0; resp_id/resp_prec/resp_data = 0; req_ready = 0; rr pointer = 0; busy = 0.
- Precision decode (mask):
  - prec 0 -> 11'h7FF (full)
  - prec 1 -> 11'h7F8
  - prec 2 -> 11'h7C0
  - prec 3 -> 11'h700
- Stage S1 (issue register): holds v1, id1, prec1, manta1, mantb1, mask1. The multiplier is driven combinationally from S1.
- Stage S2 (result register): holds v2, id2, prec2, mults2, multc2. resp_data is combinational from S2: mults2 + (multc2<<1), truncated to 11 bits.
- resp_valid = v2.
- Stall rule: adv2 = !v2 | resp_ready; adv1 = !v1 | adv2.
- Arbitration:
  - grant = first requester with req_valid high, searching from rr pointer upward with wrap.
  - req_ready[g] = adv1 & req_valid[g]; all other req_ready bits = 0. req_ready never depends on req_ready.
  - Accept = req_valid[g] & req_ready[g]. On accept, S1 loads the operands and v1 = 1, and rr = (g+1) mod NREQ.
  - rr changes only on accept.
- Moves:
  - On adv2: S2 loads S1 (v2 = v1).
  - On adv1 with no accept: v1 = 0.
- Latency: accept in cycle N -> resp_valid in cycle N+2 with no backpressure. Throughput is 1 per cycle.
- Backpressure: resp_valid high with resp_ready low holds S2 and its outputs stable. S1 is held if valid. req_ready is low for every requester while S1 is valid and S2 cannot advance.
- Simultaneous resp handshake and new accept: both proceed in the same cycle with no bubble.
- Results return in acceptance order; no reordering.
- Requester inputs are sampled only on accept; later changes have no effect.
- busy = v1 | v2.
- Reset mid-operation: in-flight entries are discarded; no response is produced for them.

Decomposition:
- Shared package mant_mul_pkg:
  - PREC_FULL=2'd0, PREC_HI=2'd1, PREC_MID=2'd2, PREC_LOW=2'd3
  - mask constants MASK_FULL=11'h7FF, MASK_HI=11'h7F8, MASK_MID=11'h7C0, MASK_LOW=11'h700
  - function prec_to_mask
- Sub-module rr_arbiter (NREQ-wide request vector, rr pointer, one-hot grant plus index). The existing mantissa multiplier is instantiated once, unchanged.

Test Plan:
- Single request, prec 0, manta=8'h80, mantb=8'h80, resp_ready=1 -> accepted at cycle N; resp_valid at N+2 with resp_data=11'h200, resp_id=0, resp_prec=0.
- Requester 1, manta=8'hC0, mantb=8'h80, prec 1 -> resp_data=11'h300, resp_id=1; repeat with mantb=8'h00 -> resp_data=11'h000.
- Both requesters valid continuously for 6 accepts, resp_ready=1 -> grants alternate 0,1,0,1,0,1; back-to-back resp_valid with matching ids and in-order data.
- resp_ready held low 5 cycles with 3 pending requests -> exactly 2 accepts, then all req_ready low; resp_data stable. Release resp_ready -> remaining results drain in order with no loss or duplication.
- Assert rst with both stages valid -> resp_valid, busy and req_ready go to 0 immediately. After release, first grant goes to requester 0 and no stale response appears.
- All 4 prec modes with manta=8'hFF, mantb=8'hFF -> resp_data equals the golden model: masked Booth partial-product sum mod 2^11. Mask correctly applied per mode; resp_prec echoes the mode.
